// File: rtl/sort4_pkg.sv
// Shared types and datapath control encodings for the 4-entry register-array sort.
package sort4_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP0,
    S_CMP1,
    S_CMP2,
    S_CHECK,
    S_DONE
  } state_t;

  // SEL bit fields: [0] reg0 edge mux, [2:1] reg1 middle mux, [4:3] reg2 middle mux, [5] reg3 edge mux
  localparam logic [5:0] SEL_LOADALL = 6'b000000;
  localparam logic [5:0] SEL_SWAP01  = 6'b000011;
  localparam logic [5:0] SEL_SWAP12  = 6'b010100;
  localparam logic [5:0] SEL_SWAP23  = 6'b101000;

  localparam logic [3:0] LD_ALL = 4'b1111;
  localparam logic [3:0] LD_01  = 4'b0011;
  localparam logic [3:0] LD_12  = 4'b0110;
  localparam logic [3:0] LD_23  = 4'b1100;

endpackage

// File: rtl/sort4_ctrl_step_timer.sv
// Step pacing counter: produces one tick every STEP_DIV enabled cycles.
module step_timer #(
  parameter int STEP_DIV = 1
) (
  input  logic CLK,
  input  logic CLR,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Wrapping on tick doubles as the per-state clear, since every busy state advances on tick
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sort4_ctrl.sv
// Master FSM for the 4-entry bubble-sort datapath: loads, compares/swaps pairs, flags DONE/ERR.
module sort4_ctrl
  import sort4_pkg::*;
#(
  parameter int STEP_DIV = 1,
  parameter int MAX_PASS = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic [2:0] LT,
  output logic [5:0] SEL,
  output logic [3:0] LD,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [2:0] PASSES
);

  state_t     state;
  logic       start_q;
  logic       swapped;
  logic       tick;
  logic       start_pulse;
  logic       go;
  logic [2:0] passes_inc;

  assign start_pulse = START & ~start_q;
  assign go          = start_pulse & ((state == S_IDLE) | (state == S_DONE));
  assign passes_inc  = (PASSES == 3'd7) ? 3'd7 : PASSES + 3'd1;

  step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .CLK   (CLK),
    .CLR   (CLR),
    .clear (go),
    .enable(BUSY),
    .tick  (tick)
  );

  // Mux selects follow the compare status directly; loads only fire on the step tick
  always_comb begin
    SEL = '0;
    LD  = '0;
    case (state)
      S_LOAD: begin
        SEL = SEL_LOADALL;
        if (tick) LD = LD_ALL;
      end
      S_CMP0: if (LT[0]) begin
        SEL = SEL_SWAP01;
        if (tick) LD = LD_01;
      end
      S_CMP1: if (LT[1]) begin
        SEL = SEL_SWAP12;
        if (tick) LD = LD_12;
      end
      S_CMP2: if (LT[2]) begin
        SEL = SEL_SWAP23;
        if (tick) LD = LD_23;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      swapped <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      PASSES  <= '0;
    end else begin
      start_q <= START;
      case (state)
        S_IDLE: if (start_pulse) begin
          state <= S_LOAD;
          BUSY  <= 1'b1;
        end
        S_LOAD: if (tick) begin
          swapped <= 1'b0;
          PASSES  <= '0;
          state   <= S_CMP0;
        end
        S_CMP0: if (tick) begin
          if (LT[0]) swapped <= 1'b1;
          state <= S_CMP1;
        end
        S_CMP1: if (tick) begin
          if (LT[1]) swapped <= 1'b1;
          state <= S_CMP2;
        end
        S_CMP2: if (tick) begin
          if (LT[2]) swapped <= 1'b1;
          state <= S_CHECK;
        end
        S_CHECK: if (tick) begin
          PASSES <= passes_inc;
          if (!swapped) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else if (int'({29'd0, passes_inc}) > MAX_PASS) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            ERR   <= 1'b1;
          end else begin
            swapped <= 1'b0;
            state   <= S_CMP0;
          end
        end
        S_DONE: if (start_pulse) begin
          state <= S_LOAD;
          BUSY  <= 1'b1;
          DONE  <= 1'b0;
          ERR   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sort4_ctrl.md
Name: sort4_ctrl

Overview:
- Master FSM for the 4-entry, 4-bit register-array sort datapath (slave circuit: four reg_nb, edge and middle muxes, three adjacent comparators).
- Loads the array from SW[15:0], then runs bubble-sort passes over pairs (0,1), (1,2), (2,3), using LT[2:0] as compare status.
- Drives mux SEL[5:0] and register LD[3:0] until the array is in descending order, then flags DONE.
- Optional step pacing makes each step visible on board LEDs/7-seg.

Parameters:
- STEP_DIV, 1, clock cycles per FSM step (≥1); 1 for simulation, e.g. 50_000_000 on board
- MAX_PASS, 4, pass limit; exceeding it raises ERR

Ports:
- CLK  in  1  system clock, rising edge
- CLR  in  1  reset, asynchronous, active-low
- START  in  1  request sort; rising edge only
- LT  in  3  LT[i]=1 when arr[i] < arr[i+1], combinational from datapath
- SEL  out  6  datapath mux selects (encoding below)
- LD  out  4  register load enables, LD[i] → reg i
- BUSY  out  1  high in LOAD/CMP0/CMP1/CMP2/CHECK
- DONE  out  1  sorted, held until next start
- ERR  out  1  pass limit exceeded, held until next start
- PASSES  out  3  completed passes of the current/last sort

Behaviour:
- Reset (CLR=0, async): state=IDLE, SEL=0, LD=0, BUSY=0, DONE=0, ERR=0, PASSES=0, swapped=0, step counter=0, START_q=0.
- start_pulse = START & ~START_q; START_q is registered each cycle. Held START starts exactly one sort.
- tick: step counter counts 0..STEP_DIV-1 in non-IDLE/non-DONE states; tick=1 on the terminal count. With STEP_DIV=1, tick is always 1. Counter clears on every state change.
- SEL/LD encoding (combinational Mealy decode; LD asserted only when tick=1):
  - LOADALL: SEL=6'b000000, LD=4'b1111 (reg i ← SW[4i+3:4i])
  - SWAP01: SEL[0]=1, SEL[2:1]=01, LD=4'b0011
  - SWAP12: SEL[2:1]=10, SEL[4:3]=10, LD=4'b0110
  - SWAP23: SEL[4:3]=01, SEL[5]=1, LD=4'b1100
  - All other cases: SEL=0, LD=0.
- Order is descending. A pair is swapped iff LT[i]=1. Equal values are never swapped, so the sort always terminates.
- States and transitions:
  - IDLE: start_pulse → LOAD.
  - LOAD: on tick, LOADALL; clear swapped and PASSES → CMP0.
  - CMPi (i=0,1,2): on tick, if LT[i] then SWAPi(i+1) and set swapped; CMP0→CMP1→CMP2→CHECK.
  - CHECK: on tick, PASSES+=1 (saturates at 7).
    - If !swapped → DONE.
    - Else if PASSES+1 > MAX_PASS → DONE with ERR=1.
    - Else clear swapped → CMP0.
  - DONE: DONE=1, BUSY=0. start_pulse → LOAD (clears DONE and ERR).
- Latency (STEP_DIV=1), counted from the cycle after start_pulse:
  - LOAD 1 cycle + 4 cycles per pass; DONE asserts the cycle after the final CHECK.
  - Sorted input: DONE at cycle 6.
  - Worst case (4 passes): DONE at cycle 18.
- LT is sampled in the same cycle LD fires. The datapath registers update at that edge; the next CMP sees the new LT.
- start_pulse while BUSY is ignored. Reset mid-sort aborts to IDLE immediately; the datapath is cleared by the same CLR.
- SW is only sampled in LOAD; SW changes during a sort have no effect.

Decomposition:
- Shared package sort4_pkg:
  - state enum (IDLE, LOAD, CMP0, CMP1, CMP2, CHECK, DONE)
  - SEL/LD localparams: SEL_LOADALL, SEL_SWAP01, SEL_SWAP12, SEL_SWAP23, LD_ALL, LD_01, LD_12, LD_23
- One sub-module: step_timer (parameter STEP_DIV; inputs CLK, CLR, clear, enable; output tick).

Test Plan:
- SW=16'h1234 (arr=4,3,2,1), START pulse → LD=1111 once, no swap LDs; PASSES=1; DONE at cycle 6; ERR=0.
- SW=16'h4321 (arr=1,2,3,4) → 6 swaps total; final arr=4,3,2,1; PASSES=4; DONE at cycle 18; ERR=0.
- SW=16'h7777 → no swaps; PASSES=1; DONE at cycle 6.
- SW=16'h3A3A (arr=A,3,A,3), START held high 40 cycles → exactly one sort; final arr=A,A,3,3; one LOAD only; a second rising edge after DONE reloads.
- CLR low during CMP1 of the 16'h4321 sort → next edge: IDLE, SEL=0, LD=0, BUSY=0, PASSES=0; START afterwards completes normally.
- STEP_DIV=3, SW=16'h1234 → each LD pulse 1 cycle wide, every 3rd cycle; DONE at cycle 16.
